// File: rtl/sample_buffer.sv
// sample_buffer: valid/ready sample capture into a first-word-fall-through buffer with sample-and-hold output.
// Optional drop counter enabled by defining SAMPLE_BUFFER_DROP_CNT_EN.
module sample_buffer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
`ifdef SAMPLE_BUFFER_DROP_CNT_EN
   output logic [7:0]                 drop_cnt,
`endif
   input  logic                       clr_ovf
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned LW  = AW + 1;

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [LW-1:0]     level_q;
   logic [WIDTH-1:0]  hold_reg;
   logic              overflow_q;
   logic              push, pop, drop;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign drop      = in_valid & ~in_ready;
   assign out_data  = out_valid ? mem[rp] : hold_reg;
   assign level     = level_q;
   assign overflow  = overflow_q;

   // Occupancy class tracks level; it exists so the handshake flags come straight from a register
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (push) state_d = PARTIAL;
         end
         PARTIAL: begin
            if (push && !pop && level_q == LW'(DEPTH - 1))
               state_d = FULL;
            else if (pop && !push && level_q == LW'(1))
               state_d = EMPTY;
         end
         FULL: begin
            if (pop) state_d = PARTIAL;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         wp         <= '0;
         rp         <= '0;
         level_q    <= '0;
         hold_reg   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wp <= wp + AW'(1);
         if (pop) begin
            rp       <= rp + AW'(1);
            hold_reg <= mem[rp];
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
         // A drop in the same cycle outranks the clear
         if (drop)         overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_data;
   end

`ifdef SAMPLE_BUFFER_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt_q <= '0;
      else if (drop && clr_ovf)
         drop_cnt_q <= 8'd1;
      else if (drop)
         drop_cnt_q <= (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
      else if (clr_ovf)
         drop_cnt_q <= '0;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sample_buffer.sv
// Directed table-driven bench for sample_buffer (WIDTH=4, DEPTH=4), plus hand sequences
// for streaming at level 1 and drop-counter saturation.
module tb_sample_buffer;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, clr_ovf;
   logic [3:0] in_data;
   logic       in_ready, out_valid, overflow;
   logic [3:0] out_data;
   logic [2:0] level;
`ifdef SAMPLE_BUFFER_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sample_buffer #(.WIDTH(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .level(level), .overflow(overflow),
`ifdef SAMPLE_BUFFER_DROP_CNT_EN
      .drop_cnt(drop_cnt),
`endif
      .clr_ovf(clr_ovf)
   );

   typedef struct {
      logic       rst, iv;
      logic [3:0] d;
      logic       ordy, clr;
      logic       e_ir, e_ov;
      logic [3:0] e_od;
      logic [2:0] e_lv;
      logic       e_of;
      int         e_dc;
   } vec_t;

   vec_t vecs [29];

   function automatic vec_t mk(logic r, logic iv, logic [3:0] d, logic o, logic c,
                               logic ir, logic ov, logic [3:0] od, logic [2:0] lv,
                               logic of, int dc);
      vec_t v;
      v.rst = r; v.iv = iv; v.d = d; v.ordy = o; v.clr = c;
      v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_lv = lv; v.e_of = of; v.e_dc = dc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [3:0] d,
                        input logic o, input logic c);
      rst = r; in_valid = iv; in_data = d; out_ready = o; clr_ovf = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input int idx, input logic ir, input logic ov, input logic [3:0] od,
                          input logic [2:0] lv, input logic of, input int dc);
      chk("in_ready", idx, int'(in_ready), int'(ir));
      chk("out_valid", idx, int'(out_valid), int'(ov));
      chk("out_data", idx, int'(out_data), int'(od));
      chk("level", idx, int'(level), int'(lv));
      chk("overflow", idx, int'(overflow), int'(of));
`ifdef SAMPLE_BUFFER_DROP_CNT_EN
      chk("drop_cnt", idx, int'(drop_cnt), dc);
`else
      if (dc < 0) $display("unexpected negative drop count");
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; clr_ovf = 1'b0;

      //             rst iv d      or clr | ir ov od     lv of dc
      vecs[0]  = mk(1, 0, 4'h0, 0, 0,   1, 0, 4'h0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 4'h0, 0, 0,   1, 0, 4'h0, 0, 0, 0);
      vecs[2]  = mk(0, 1, 4'hA, 0, 0,   1, 1, 4'hA, 1, 0, 0);
      vecs[3]  = mk(0, 1, 4'hC, 0, 0,   1, 1, 4'hA, 2, 0, 0);
      vecs[4]  = mk(0, 1, 4'h0, 0, 0,   1, 1, 4'hA, 3, 0, 0);
      vecs[5]  = mk(0, 0, 4'h0, 1, 0,   1, 1, 4'hC, 2, 0, 0);
      vecs[6]  = mk(0, 0, 4'h0, 1, 0,   1, 1, 4'h0, 1, 0, 0);
      vecs[7]  = mk(0, 0, 4'h0, 1, 0,   1, 0, 4'h0, 0, 0, 0);
      vecs[8]  = mk(0, 1, 4'h5, 0, 0,   1, 1, 4'h5, 1, 0, 0);
      vecs[9]  = mk(0, 0, 4'h0, 1, 0,   1, 0, 4'h5, 0, 0, 0);
      vecs[10] = mk(0, 1, 4'h1, 0, 0,   1, 1, 4'h1, 1, 0, 0);
      vecs[11] = mk(0, 1, 4'h2, 0, 0,   1, 1, 4'h1, 2, 0, 0);
      vecs[12] = mk(0, 1, 4'h3, 0, 0,   1, 1, 4'h1, 3, 0, 0);
      vecs[13] = mk(0, 1, 4'h4, 0, 0,   0, 1, 4'h1, 4, 0, 0);
      vecs[14] = mk(0, 1, 4'h5, 0, 0,   0, 1, 4'h1, 4, 1, 1);
      vecs[15] = mk(0, 0, 4'h0, 1, 0,   1, 1, 4'h2, 3, 1, 1);
      vecs[16] = mk(0, 0, 4'h0, 1, 0,   1, 1, 4'h3, 2, 1, 1);
      vecs[17] = mk(0, 0, 4'h0, 1, 0,   1, 1, 4'h4, 1, 1, 1);
      vecs[18] = mk(0, 0, 4'h0, 1, 0,   1, 0, 4'h4, 0, 1, 1);
      vecs[19] = mk(0, 0, 4'h0, 0, 1,   1, 0, 4'h4, 0, 0, 0);
      vecs[20] = mk(0, 1, 4'h1, 0, 0,   1, 1, 4'h1, 1, 0, 0);
      vecs[21] = mk(0, 1, 4'h2, 0, 0,   1, 1, 4'h1, 2, 0, 0);
      vecs[22] = mk(0, 1, 4'h3, 0, 0,   1, 1, 4'h1, 3, 0, 0);
      vecs[23] = mk(0, 1, 4'h4, 0, 0,   0, 1, 4'h1, 4, 0, 0);
      vecs[24] = mk(0, 1, 4'h7, 1, 0,   1, 1, 4'h2, 3, 1, 1);
      vecs[25] = mk(0, 1, 4'h7, 0, 1,   0, 1, 4'h2, 4, 0, 0);
      vecs[26] = mk(0, 1, 4'h8, 0, 1,   0, 1, 4'h2, 4, 1, 1);
      vecs[27] = mk(0, 0, 4'h0, 1, 0,   1, 1, 4'h3, 3, 1, 1);
      vecs[28] = mk(1, 1, 4'h9, 1, 0,   1, 0, 4'h0, 0, 0, 0);

      for (int i = 0; i < 29; i++) begin
         drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr);
         chk_all(i, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_lv,
                 vecs[i].e_of, vecs[i].e_dc);
      end

      // Streaming at level 1 across pointer wrap: values 0..9 in order
      drive(0, 1, 4'd0, 0, 0);
      chk_all(100, 1, 1, 4'd0, 1, 0, 0);
      for (int k = 1; k < 10; k++) begin
         drive(0, 1, 4'(k), 1, 0);
         chk_all(100 + k, 1, 1, 4'(k), 1, 0, 0);
      end
      drive(0, 0, 4'd0, 1, 0);
      chk_all(110, 1, 0, 4'd9, 0, 0, 0);

`ifdef SAMPLE_BUFFER_DROP_CNT_EN
      // Drop counter saturation at 255
      for (int k = 0; k < 4; k++) drive(0, 1, 4'(k), 0, 0);
      for (int k = 0; k < 260; k++) drive(0, 1, 4'hF, 0, 0);
      chk("drop_cnt_sat", 200, int'(drop_cnt), 255);
      chk("overflow_sat", 200, int'(overflow), 1);
      drive(0, 0, 4'h0, 0, 1);
      chk("drop_cnt_clr", 201, int'(drop_cnt), 0);
      chk("overflow_clr", 201, int'(overflow), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_buffer.md
# sample_buffer

Parametrised successor to the 4-bit `sample` stage. It captures WIDTH-bit samples through a valid/ready handshake into a DEPTH-entry first-word-fall-through buffer. When the buffer is empty, it holds the last delivered sample on its output. It sits between a sample producer and a consumer that may stall, and reports buffer level and sticky overflow.

## Interface
- WIDTH, 4, sample width in bits (≥1)
- DEPTH, 4, buffer entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers in_data this cycle
- in_data  input  WIDTH  sample value
- in_ready  output  1  buffer accepts a sample this cycle
- out_valid  output  1  out_data is a buffered sample
- out_data  output  WIDTH  head sample, or last delivered sample when empty
- out_ready  input  1  consumer takes the head this cycle
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a sample was offered while full
- clr_ovf  input  1  clears overflow

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp, read pointer rp, both $clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy is counted in level.
- in_ready = (level != DEPTH). It does not depend on out_ready; a full buffer never accepts, even while popping.
- push = in_valid & in_ready. Writes mem[wp] and increments wp.
- out_valid = (level != 0).
- pop = out_valid & out_ready. Increments rp and loads hold_reg ← mem[rp].
- out_data = mem[rp] when out_valid, else hold_reg (sample-and-hold).
- level: +1 on push only, −1 on pop only, unchanged on push&pop.
- Drop: in_valid & !in_ready discards the sample and sets overflow.
- overflow: the set condition has priority over clr_ovf in the same cycle. clr_ovf alone clears it.
- FSM view, derived from level: EMPTY (0), PARTIAL (1..DEPTH−1), FULL (DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop when level=DEPTH−1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push when level=1.
- Reset: wp=rp=0, level=0, hold_reg=0, overflow=0, drop counter=0. Memory contents are not reset.

## Timing
- Reset outputs: in_ready=1, out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0.
- Latency: a sample pushed in cycle N appears on out_data with out_valid=1 in cycle N+1, including when the buffer is empty. There is no combinational in→out bypass.
- in_ready, out_valid, level and overflow are registered or derived only from registers. They have no combinational path from in_valid or out_ready.
- Push and pop in the same cycle at level 1: level stays 1, and out_data shows the new sample next cycle.
- Pop at level 1 without push: the next cycle has out_valid=0 and out_data equal to the just-popped value.
- rst asserted mid-transfer: the next cycle matches the reset state, and in-flight samples are lost.

## Configuration
- SAMPLE_BUFFER_DROP_CNT_EN
  - Defined: adds output drop_cnt (8 bits), which increments on each dropped sample. It saturates at 255 and is cleared by rst or clr_ovf. An increment wins over clr_ovf in the same cycle, giving value 1.
  - Undefined: no drop_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Reset then idle: after rst, in_ready=1, out_valid=0, out_data=0000, level=0, overflow=0.
- Push 1010, 1100, 0000 on consecutive cycles with out_ready=0 → level goes 1,2,3. Then out_ready=1 pops in order 1010, 1100, 0000, one per cycle. Afterwards out_valid=0 and out_data holds 0000, then after new push 0101 and pop holds 0101.
- Fill 4 entries (1,2,3,4), then offer 5 with out_ready=0 → in_ready=0 and overflow=1. Pops return 1,2,3,4 only. With the macro, drop_cnt=1.
- Full buffer, in_valid=1 (7) and out_ready=1 in the same cycle → 1 popped, 7 dropped, level=3, overflow=1. Next cycle in_ready=1.
- Continuous push/pop at level 1 for 10 cycles (values 0..9) with pointer wrap → level constant at 1, output in order 0..9, no overflow.
- clr_ovf with overflow=1 and no drop → overflow=0 next cycle. clr_ovf together with a drop → overflow stays 1. Assert rst with level=3 → all outputs at reset values next cycle.
